hazard_scoreboard: RTL and testbench

- Next-generation operand-hazard block for the core pipeline; replaces purely combinational EX-stage forwarding.
- Handles N source operands and computes forwarding selects one stage early, in ID, then registers them into EX.
- Detects load-use hazards and tracks outstanding long-latency writes (div/vector/mem-miss) in a per-register scoreboard.
- Drives ID stall / EX bubble insertion and keeps saturating stall statistics.

---
 rtl/core_hazard_pkg.sv | 18 +
 rtl/hazard_sat_counter.sv | 23 ++
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_hazard_pkg.sv
// Shared types for the operand-hazard logic: forwarding select encoding and stall causes.
package core_hazard_pkg;

   localparam int unsigned DEFAULT_REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      NONE,
      LOAD_USE,
      SCOREBOARD
   } stall_cause_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (en && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use and long-latency scoreboard stalls, forwarding selects
// computed in ID and registered into EX, plus saturating stall statistics.
module hazard_scoreboard
   import core_hazard_pkg::*;
#(
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pipe_hold,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]         id_rd_addr,
   input  logic                          id_reg_write,
   input  logic                          id_long_lat,
   input  logic                          ex_valid,
   input  logic                          ex_reg_write,
   input  logic                          ex_is_load,
   input  logic [REG_ADDR_W-1:0]         ex_rd_addr,
   input  logic                          mem_reg_write,
   input  logic [REG_ADDR_W-1:0]         mem_rd_addr,
   input  logic                          lat_done,
   input  logic [REG_ADDR_W-1:0]         lat_done_rd,
   output logic [NUM_SRC*2-1:0]          fwd_sel,
   output logic                          stall_id,
   output logic                          ex_bubble,
   output logic [2**REG_ADDR_W-1:0]      sb_pending,
   output logic [CNT_W-1:0]              stall_ld_cnt,
   output logic [CNT_W-1:0]              stall_sb_cnt
);

   localparam int unsigned NUM_REGS = 2**REG_ADDR_W;

   logic [REG_ADDR_W-1:0] rs [NUM_SRC];
   logic [NUM_SRC-1:0]    cand;
   logic [NUM_SRC-1:0]    ld_hit;
   logic [NUM_SRC-1:0]    sb_hit;
   logic                  load_use;
   logic                  waw_hit;
   logic                  sb_haz;
   logic                  issue;
   logic                  sb_set;
   logic                  ex_alu_prod;
   logic                  ex_ld_prod;
   stall_cause_e          cause;

   logic [NUM_SRC*2-1:0]  fwd_d, fwd_q;
   logic                  bubble_q;
   logic [NUM_REGS-1:0]   pend_d, pend_q;

   assign ex_alu_prod = ex_valid & ex_reg_write & ~ex_is_load;
   assign ex_ld_prod  = ex_valid & ex_reg_write & ex_is_load;

   always_comb begin
      cand  = '0;
      ld_hit = '0;
      sb_hit = '0;
      fwd_d  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rs[k]     = id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W];
         cand[k]   = id_rs_used[k] && (rs[k] != '0);
         ld_hit[k] = cand[k] && ex_ld_prod && (rs[k] == ex_rd_addr);
         sb_hit[k] = cand[k] && pend_q[rs[k]];
         // EX result is in MEM next cycle, MEM result in WB; EX is the younger producer.
         if (cand[k] && ex_alu_prod && (rs[k] == ex_rd_addr)) begin
            fwd_d[k*2 +: 2] = FWD_MEM;
         end else if (cand[k] && mem_reg_write && (rs[k] == mem_rd_addr)) begin
            fwd_d[k*2 +: 2] = FWD_WB;
         end else begin
            fwd_d[k*2 +: 2] = FWD_RF;
         end
      end
   end

   assign load_use = |ld_hit;
   assign waw_hit  = id_reg_write && (id_rd_addr != '0) && pend_q[id_rd_addr];
   assign sb_haz   = (|sb_hit) | waw_hit;
   assign stall_id = id_valid & (load_use | sb_haz);
   assign issue    = id_valid & ~stall_id;
   assign sb_set   = ~pipe_hold & issue & id_long_lat & id_reg_write & (id_rd_addr != '0);

   always_comb begin
      cause = NONE;
      if (id_valid && load_use) begin
         cause = LOAD_USE;
      end else if (id_valid && sb_haz) begin
         cause = SCOREBOARD;
      end
   end

   // Clear first so a same-cycle set on the same index wins.
   always_comb begin
      pend_d = pend_q;
      if (lat_done) begin
         pend_d[lat_done_rd] = 1'b0;
      end
      if (sb_set) begin
         pend_d[id_rd_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_q    <= '0;
         bubble_q <= 1'b1;
         pend_q   <= '0;
      end else begin
         pend_q <= pend_d;
         if (!pipe_hold) begin
            fwd_q    <= issue ? fwd_d : '0;
            bubble_q <= ~issue;
         end
      end
   end

   assign fwd_sel    = fwd_q;
   assign ex_bubble  = bubble_q;
   assign sb_pending = pend_q;

   hazard_sat_counter #(
      .WIDTH (CNT_W)
   ) u_ld_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cause == LOAD_USE),
      .count (stall_ld_cnt)
   );

   hazard_sat_counter #(
      .WIDTH (CNT_W)
   ) u_sb_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cause == SCOREBOARD),
      .count (stall_sb_cnt)
   );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a per-cycle behavioural model.
module tb_hazard_scoreboard;

   localparam int NS   = 3;
   localparam int AW   = 5;
   localparam int CW   = 4;
   localparam int NREG = 2**AW;
   localparam int CMAX = 2**CW - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pipe_hold;
   logic              id_valid;
   logic [NS*AW-1:0]  id_rs_addr;
   logic [NS-1:0]     id_rs_used;
   logic [AW-1:0]     id_rd_addr;
   logic              id_reg_write;
   logic              id_long_lat;
   logic              ex_valid, ex_reg_write, ex_is_load;
   logic [AW-1:0]     ex_rd_addr;
   logic              mem_reg_write;
   logic [AW-1:0]     mem_rd_addr;
   logic              lat_done;
   logic [AW-1:0]     lat_done_rd;
   logic [NS*2-1:0]   fwd_sel;
   logic              stall_id;
   logic              ex_bubble;
   logic [NREG-1:0]   sb_pending;
   logic [CW-1:0]     stall_ld_cnt, stall_sb_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: plain integers/bits, one entry per architectural register.
   bit m_pend [NREG];
   int m_fwd  [NS];
   bit m_bubble;
   int m_ld, m_sb;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NUM_SRC    (NS),
      .REG_ADDR_W (AW),
      .CNT_W      (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pipe_hold     (pipe_hold),
      .id_valid      (id_valid),
      .id_rs_addr    (id_rs_addr),
      .id_rs_used    (id_rs_used),
      .id_rd_addr    (id_rd_addr),
      .id_reg_write  (id_reg_write),
      .id_long_lat   (id_long_lat),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_is_load    (ex_is_load),
      .ex_rd_addr    (ex_rd_addr),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .lat_done      (lat_done),
      .lat_done_rd   (lat_done_rd),
      .fwd_sel       (fwd_sel),
      .stall_id      (stall_id),
      .ex_bubble     (ex_bubble),
      .sb_pending    (sb_pending),
      .stall_ld_cnt  (stall_ld_cnt),
      .stall_sb_cnt  (stall_sb_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      foreach (m_fwd[k]) m_fwd[k] = 0;
      m_bubble = 1'b1;
      m_ld = 0;
      m_sb = 0;
   endtask

   task automatic check_regs(input string tag);
      logic [NS*2-1:0] ef;
      logic [NREG-1:0] ep;
      for (int k = 0; k < NS; k++) ef[k*2 +: 2] = 2'(m_fwd[k]);
      for (int i = 0; i < NREG; i++) ep[i] = m_pend[i];
      check({tag, ".fwd_sel"}, 64'(fwd_sel), 64'(ef));
      check({tag, ".ex_bubble"}, 64'(ex_bubble), 64'(m_bubble));
      check({tag, ".sb_pending"}, 64'(sb_pending), 64'(ep));
      check({tag, ".stall_ld_cnt"}, 64'(stall_ld_cnt), 64'(m_ld));
      check({tag, ".stall_sb_cnt"}, 64'(stall_sb_cnt), 64'(m_sb));
   endtask

   task automatic idle();
      pipe_hold = 0; id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0;
      id_reg_write = 0; id_long_lat = 0; ex_valid = 0; ex_reg_write = 0; ex_is_load = 0;
      ex_rd_addr = '0; mem_reg_write = 0; mem_rd_addr = '0; lat_done = 0; lat_done_rd = '0;
   endtask

   function automatic logic [NS*AW-1:0] rs_vec(input int a0, input int a1, input int a2);
      logic [NS*AW-1:0] v;
      v = {AW'(a2), AW'(a1), AW'(a0)};
      return v;
   endfunction

   // One clock: check combinational stall at negedge, advance model at posedge, check regs.
   task automatic cycle(input string tag);
      bit ld, sb, stall, issue;
      int ef [NS];
      int rs;
      bit cand;
      @(negedge clk);
      ld = 0;
      sb = 0;
      for (int k = 0; k < NS; k++) begin
         rs   = int'(id_rs_addr[k*AW +: AW]);
         cand = id_rs_used[k] && rs != 0;
         ef[k] = 0;
         if (cand) begin
            if (ex_valid && ex_reg_write && ex_is_load && rs == int'(ex_rd_addr)) ld = 1;
            if (m_pend[rs]) sb = 1;
            if (ex_valid && ex_reg_write && !ex_is_load && rs == int'(ex_rd_addr)) ef[k] = 2;
            else if (mem_reg_write && rs == int'(mem_rd_addr)) ef[k] = 1;
         end
      end
      if (id_reg_write && id_rd_addr != 0 && m_pend[id_rd_addr]) sb = 1;
      stall = id_valid && (ld || sb);
      issue = id_valid && !stall;
      check({tag, ".stall_id"}, 64'(stall_id), 64'(stall));
      @(posedge clk);
      if (stall && ld) m_ld = (m_ld < CMAX) ? m_ld + 1 : CMAX;
      else if (stall) m_sb = (m_sb < CMAX) ? m_sb + 1 : CMAX;
      if (lat_done) m_pend[lat_done_rd] = 1'b0;
      if (!pipe_hold && issue && id_long_lat && id_reg_write && id_rd_addr != 0)
         m_pend[id_rd_addr] = 1'b1;
      if (!pipe_hold) begin
         m_bubble = !issue;
         for (int k = 0; k < NS; k++) m_fwd[k] = issue ? ef[k] : 0;
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      #12;
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ALU chain: ADD x5 in EX, consumer reads x5 on operand 0.
      idle();
      ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 5;
      id_valid = 1; id_rs_used = 3'b001; id_rs_addr = rs_vec(5, 0, 0);
      cycle("alu");
      check("alu.sel0", 64'(fwd_sel[1:0]), 64'(2'b10));
      check("alu.bubble", 64'(ex_bubble), 64'(0));

      // EX beats MEM for the same register; then MEM alone.
      mem_reg_write = 1; mem_rd_addr = 7; ex_rd_addr = 7;
      id_rs_used = 3'b010; id_rs_addr = rs_vec(0, 7, 0);
      cycle("prio_ex");
      check("prio_ex.sel1", 64'(fwd_sel[3:2]), 64'(2'b10));
      ex_rd_addr = 3;
      cycle("prio_mem");
      check("prio_mem.sel1", 64'(fwd_sel[3:2]), 64'(2'b01));

      // Load-use then the load moves to MEM.
      idle();
      ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd_addr = 9;
      id_valid = 1; id_rs_used = 3'b001; id_rs_addr = rs_vec(9, 0, 0);
      cycle("ld_use");
      check("ld_use.bubble", 64'(ex_bubble), 64'(1));
      check("ld_use.cnt", 64'(stall_ld_cnt), 64'(1));
      ex_valid = 0; ex_is_load = 0; mem_reg_write = 1; mem_rd_addr = 9;
      cycle("ld_after");
      check("ld_after.bubble", 64'(ex_bubble), 64'(0));

      // Long-latency producer x12, then a consumer waits on the scoreboard.
      idle();
      id_valid = 1; id_reg_write = 1; id_long_lat = 1; id_rd_addr = 12;
      cycle("div");
      check("div.pend12", 64'(sb_pending[12]), 64'(1));
      idle();
      id_valid = 1; id_rs_used = 3'b100; id_rs_addr = rs_vec(0, 0, 12);
      for (int i = 0; i < 20; i++) cycle("sb_wait");
      check("sb_wait.sat", 64'(stall_sb_cnt), 64'(CMAX));
      lat_done = 1; lat_done_rd = 12;
      cycle("sb_done");
      check("sb_done.still_stall", 64'(ex_bubble), 64'(1));
      lat_done = 0;
      cycle("sb_release");
      check("sb_release.sel", 64'(fwd_sel), 64'(0));
      check("sb_release.bubble", 64'(ex_bubble), 64'(0));

      // x0 never forwards or stalls.
      idle();
      ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; mem_reg_write = 1;
      id_valid = 1; id_rs_used = 3'b111; id_rs_addr = rs_vec(0, 0, 0);
      cycle("x0");
      check("x0.sel", 64'(fwd_sel), 64'(0));

      // Hold while stalled: registered outputs freeze.
      idle();
      id_valid = 1; id_reg_write = 1; id_long_lat = 1; id_rd_addr = 20;
      cycle("hold_set");
      idle();
      id_valid = 1; id_rs_used = 3'b001; id_rs_addr = rs_vec(20, 0, 0); pipe_hold = 1;
      for (int i = 0; i < 3; i++) cycle("hold");
      check("hold.bubble", 64'(ex_bubble), 64'(0));

      // Same-index clear and set in one cycle: set wins.
      idle();
      lat_done = 1; lat_done_rd = 15;
      id_valid = 1; id_reg_write = 1; id_long_lat = 1; id_rd_addr = 15;
      cycle("set_clr");
      check("set_clr.pend15", 64'(sb_pending[15]), 64'(1));

      // Randomized traffic over a small register range to provoke matches.
      for (int n = 0; n < 400; n++) begin
         pipe_hold     = ($urandom_range(0, 4) == 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         id_rs_addr    = rs_vec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         id_rs_used    = NS'($urandom);
         id_rd_addr    = AW'($urandom_range(0, 7));
         id_reg_write  = $urandom_range(0, 1);
         id_long_lat   = ($urandom_range(0, 5) == 0);
         ex_valid      = $urandom_range(0, 1);
         ex_reg_write  = $urandom_range(0, 1);
         ex_is_load    = ($urandom_range(0, 3) == 0);
         ex_rd_addr    = AW'($urandom_range(0, 7));
         mem_reg_write = $urandom_range(0, 1);
         mem_rd_addr   = AW'($urandom_range(0, 7));
         lat_done      = ($urandom_range(0, 2) == 0);
         lat_done_rd   = AW'($urandom_range(0, 7));
         cycle("rand");
      end

      // Asynchronous reset in the middle of a scoreboard stall.
      idle();
      id_valid = 1; id_reg_write = 1; id_long_lat = 1; id_rd_addr = 6;
      cycle("mid_set");
      idle();
      id_valid = 1; id_rs_used = 3'b001; id_rs_addr = rs_vec(6, 0, 0);
      cycle("mid_stall");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_regs("mid_reset");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      cycle("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
